// File: rtl/isp_pkg.sv
// Shared ISP types: pixel format, pad sequencer states and border helper.
package isp_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  typedef enum logic [2:0] {IDLE, TOP, LPAD, DATA, RPAD, BOT, FLUSH, DONE} pad_state_t;

  // Border width for a KxK window.
  function automatic int unsigned pad_border(input int unsigned k);
    return (k - 1) / 2;
  endfunction

endpackage

// File: rtl/filter_pad_sequencer_if.sv
// Demosaic-to-filter stream bundle for the pad sequencer.
interface filter_pad_sequencer_if;
  import isp_pkg::*;

  logic   start;
  logic   iValid;
  logic   iReady;
  pixel_t iData;
  logic   oValid;
  pixel_t oData;
  logic   oBusy;
  logic   oDone;

  modport master (output start, iValid, iData, input iReady, oValid, oData, oBusy, oDone);
  modport slave  (input start, iValid, iData, output iReady, oValid, oData, oBusy, oDone);
endinterface

// File: rtl/pad_xy_counter.sv
// Column/row counters with enables, dynamic terminal values and wrap to zero.
module pad_xy_counter #(
  parameter int unsigned COL_W = 4,
  parameter int unsigned ROW_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             colEn,
  input  logic [COL_W-1:0] colMax,
  input  logic             rowEn,
  input  logic [ROW_W-1:0] rowMax,
  output logic             colLast_c,
  output logic             rowLast_c
);
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;

  assign colLast_c = (col == colMax);
  assign rowLast_c = (row == rowMax);

  // Advance counters; wrap to zero on terminal count.
  always_ff @(posedge clk) begin
    if (reset) begin
      col <= '0;
      row <= '0;
    end else begin
      if (colEn) col <= colLast_c ? '0 : col + COL_W'(1);
      if (rowEn) row <= rowLast_c ? '0 : row + ROW_W'(1);
    end
  end
endmodule

// File: rtl/filter_pad_sequencer.sv
// Pads a demosaic frame for a KxK filter: zero top rows, per-row left/right
// padding, zero bottom rows, then a zero flush. Optional macro
// FILTER_PAD_REPLICATE_EN replicates edge pixels for column padding.
module filter_pad_sequencer
  import isp_pkg::*;
#(
  parameter int unsigned WIDTH        = 320,
  parameter int unsigned HEIGHT       = 240,
  parameter int unsigned KERNEL_SIZE  = 7,
  parameter int unsigned FLUSH_CYCLES = 994
) (
  input  logic                   clk,
  input  logic                   reset,
  filter_pad_sequencer_if.slave  bus
);
  localparam int unsigned B        = pad_border(KERNEL_SIZE);
  localparam int unsigned ROW_LEN  = WIDTH + 2 * B;
  localparam int unsigned ROW_SPAN = (HEIGHT > B) ? HEIGHT : B;
  localparam int unsigned COL_W    = $clog2(ROW_LEN + 1);
  localparam int unsigned ROW_W    = $clog2(ROW_SPAN + 1);
  localparam int unsigned FLUSH_W  = $clog2(FLUSH_CYCLES + 1);
`ifdef FILTER_PAD_REPLICATE_EN
  // LPAD also carries DATA column 0 (the edge pixel), so DATA takes one beat fewer.
  localparam int unsigned LPAD_LAST = B;
  localparam int unsigned DATA_LAST = WIDTH - 2;
`else
  localparam int unsigned LPAD_LAST = B - 1;
  localparam int unsigned DATA_LAST = WIDTH - 1;
`endif

  pad_state_t         state, stateNext;
  logic               oValidR, oValidNext;
  pixel_t             oDataR, oDataNext;
  logic               iReadyR, iReadyNext;
  logic               oBusyR, oBusyNext;
  logic               oDoneR, oDoneNext;
  logic [FLUSH_W-1:0] flushCnt, flushCntNext;
  logic               colEn, rowEn, colLast, rowLast;
  logic [COL_W-1:0]   colMax;
  logic [ROW_W-1:0]   rowMax;
  logic               xfer;
`ifdef FILTER_PAD_REPLICATE_EN
  pixel_t             edgePix, edgePixNext;
  logic               edgeHeld, edgeHeldNext;
`endif

  assign xfer = bus.iValid & iReadyR;

  pad_xy_counter #(.COL_W(COL_W), .ROW_W(ROW_W)) xyCnt (
    .clk       (clk),
    .reset     (reset),
    .colEn     (colEn),
    .colMax    (colMax),
    .rowEn     (rowEn),
    .rowMax    (rowMax),
    .colLast_c (colLast),
    .rowLast_c (rowLast)
  );

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      oValidR  <= 1'b0;
      oDataR   <= '0;
      iReadyR  <= 1'b0;
      oBusyR   <= 1'b0;
      oDoneR   <= 1'b0;
      flushCnt <= '0;
`ifdef FILTER_PAD_REPLICATE_EN
      edgePix  <= '0;
      edgeHeld <= 1'b0;
`endif
    end else begin
      state    <= stateNext;
      oValidR  <= oValidNext;
      oDataR   <= oDataNext;
      iReadyR  <= iReadyNext;
      oBusyR   <= oBusyNext;
      oDoneR   <= oDoneNext;
      flushCnt <= flushCntNext;
`ifdef FILTER_PAD_REPLICATE_EN
      edgePix  <= edgePixNext;
      edgeHeld <= edgeHeldNext;
`endif
    end
  end

  // Next state, counter control and next output values.
  always_comb begin
    stateNext    = state;
    oValidNext   = 1'b0;
    oDataNext    = '0;
    iReadyNext   = 1'b0;
    oBusyNext    = oBusyR;
    oDoneNext    = 1'b0;
    flushCntNext = flushCnt;
    colEn        = 1'b0;
    rowEn        = 1'b0;
    colMax       = '0;
    rowMax       = '0;
`ifdef FILTER_PAD_REPLICATE_EN
    edgePixNext  = edgePix;
    edgeHeldNext = edgeHeld;
`endif
    unique case (state)
      IDLE: begin
        // oDone is still high on the first IDLE cycle; a start then is ignored.
        if (bus.start && !oDoneR) begin
          stateNext = TOP;
          oBusyNext = 1'b1;
        end
      end
      TOP, BOT: begin
        oValidNext = 1'b1;
        colEn      = 1'b1;
        colMax     = COL_W'(ROW_LEN - 1);
        rowMax     = ROW_W'(B - 1);
        rowEn      = colLast;
        if (colLast && rowLast) begin
          if (state == TOP) begin
            stateNext = LPAD;
          end else begin
            stateNext    = FLUSH;
            flushCntNext = FLUSH_W'(FLUSH_CYCLES - 1);
          end
        end
      end
      LPAD: begin
        colMax = COL_W'(LPAD_LAST);
`ifdef FILTER_PAD_REPLICATE_EN
        if (!edgeHeld) begin
          if (xfer) begin
            edgeHeldNext = 1'b1;
            edgePixNext  = bus.iData;
          end
        end else begin
          oValidNext = 1'b1;
          oDataNext  = edgePix;
          colEn      = 1'b1;
          if (colLast) begin
            stateNext    = DATA;
            edgeHeldNext = 1'b0;
          end
        end
`else
        oValidNext = 1'b1;
        colEn      = 1'b1;
        if (colLast) stateNext = DATA;
`endif
      end
      DATA: begin
        colMax = COL_W'(DATA_LAST);
        if (xfer) begin
          oValidNext = 1'b1;
          oDataNext  = bus.iData;
          colEn      = 1'b1;
`ifdef FILTER_PAD_REPLICATE_EN
          edgePixNext = bus.iData;
`endif
          if (colLast) stateNext = RPAD;
        end
      end
      RPAD: begin
        oValidNext = 1'b1;
`ifdef FILTER_PAD_REPLICATE_EN
        oDataNext  = edgePix;
`endif
        colEn      = 1'b1;
        colMax     = COL_W'(B - 1);
        rowMax     = ROW_W'(HEIGHT - 1);
        rowEn      = colLast;
        if (colLast) stateNext = rowLast ? BOT : LPAD;
      end
      FLUSH: begin
        oValidNext = 1'b1;
        if (flushCnt == '0) stateNext = DONE;
        else                flushCntNext = flushCnt - FLUSH_W'(1);
      end
      DONE: begin
        oDoneNext = 1'b1;
        oBusyNext = 1'b0;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
    iReadyNext = (stateNext == DATA);
`ifdef FILTER_PAD_REPLICATE_EN
    if (stateNext == LPAD && !edgeHeldNext) iReadyNext = 1'b1;
`endif
  end

  assign bus.iReady = iReadyR;
  assign bus.oValid = oValidR;
  assign bus.oData  = oDataR;
  assign bus.oBusy  = oBusyR;
  assign bus.oDone  = oDoneR;
endmodule

// File: tb/tb_filter_pad_sequencer.sv
// Directed bench for filter_pad_sequencer: small-geometry cycle table,
// stall/restart/abort sequences and a full default-size beat count.
module tb_filter_pad_sequencer;
  import isp_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  filter_pad_sequencer_if sIf ();
  filter_pad_sequencer_if dIf ();

  filter_pad_sequencer #(.WIDTH(4), .HEIGHT(2), .KERNEL_SIZE(3), .FLUSH_CYCLES(5)) dutS (
    .clk(clk), .reset(reset), .bus(sIf.slave));
  filter_pad_sequencer dutD (.clk(clk), .reset(reset), .bus(dIf.slave));

  typedef struct {
    logic        start;
    logic        iValid;
    logic [23:0] iData;
    logic        eValid;
    logic [23:0] eData;
    logic        eReady;
    logic        eBusy;
    logic        eDone;
  } vec_t;

  localparam logic [23:0] JUNK = 24'hFFFFFF;

  vec_t        vecs[$];
  pixel_t      got[$];
  logic [23:0] expBeats[$];
  int          nChecks = 0;
  int          nFails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic st, input logic [23:0] d, input logic ev,
                              input logic [23:0] ed, input logic er, input logic eb,
                              input logic edn);
    vec_t v;
    v.start = st; v.iValid = 1'b1; v.iData = d; v.eValid = ev; v.eData = ed;
    v.eReady = er; v.eBusy = eb; v.eDone = edn;
    return v;
  endfunction

  task automatic compareBeats(input string tag);
    check({tag, "_beatCount"}, 32'(got.size()), 32'(expBeats.size()));
    for (int i = 0; i < got.size() && i < expBeats.size(); i++)
      check($sformatf("%s_beat%0d", tag, i), 32'(got[i]), 32'(expBeats[i]));
  endtask

  // One small frame with a handshaking upstream; optional iValid toggling and stray starts.
  task automatic runFrame(input bit toggle, input bit pokeStart, output int dones);
    int idx = 0;
    int cyc = 0;
    int after = 0;
    bit acc;
    got.delete();
    dones = 0;
    @(negedge clk);
    sIf.start = 1'b1; sIf.iValid = 1'b0;
    @(posedge clk); #1;
    while (cyc < 200 && after < 4) begin
      @(negedge clk);
      sIf.start  = pokeStart && ((cyc == 3) || (cyc == 10) || (sIf.oDone == 1'b1));
      sIf.iValid = toggle ? ((cyc % 2) == 0) : 1'b1;
      sIf.iData  = pixel_t'(24'(idx + 1));
      acc = sIf.iValid && sIf.iReady;
      @(posedge clk); #1;
      if (acc) idx++;
      if (sIf.oValid) got.push_back(sIf.oData);
      if (sIf.oDone) dones++;
      if (dones > 0) after++;
      cyc++;
    end
    sIf.start = 1'b0;
    check("frameFinished", 32'(after >= 4), 32'd1);
  endtask

  initial begin
    int dn;
    sIf.start = 1'b0; sIf.iValid = 1'b0; sIf.iData = '0;
    dIf.start = 1'b0; dIf.iValid = 1'b0; dIf.iData = '0;

    // Expected padded beat order for the small frame.
    repeat (6) expBeats.push_back(24'h0);
`ifdef FILTER_PAD_REPLICATE_EN
    expBeats.push_back(24'h1); expBeats.push_back(24'h1); expBeats.push_back(24'h2);
    expBeats.push_back(24'h3); expBeats.push_back(24'h4); expBeats.push_back(24'h4);
    expBeats.push_back(24'h5); expBeats.push_back(24'h5); expBeats.push_back(24'h6);
    expBeats.push_back(24'h7); expBeats.push_back(24'h8); expBeats.push_back(24'h8);
`else
    expBeats.push_back(24'h0); expBeats.push_back(24'h1); expBeats.push_back(24'h2);
    expBeats.push_back(24'h3); expBeats.push_back(24'h4); expBeats.push_back(24'h0);
    expBeats.push_back(24'h0); expBeats.push_back(24'h5); expBeats.push_back(24'h6);
    expBeats.push_back(24'h7); expBeats.push_back(24'h8); expBeats.push_back(24'h0);
`endif
    repeat (11) expBeats.push_back(24'h0);

    // Cycle table, iValid held high: record k = inputs before edge k, outputs after it.
    vecs.push_back(mk(1, JUNK, 0, 0, 0, 1, 0));
`ifdef FILTER_PAD_REPLICATE_EN
    for (int k = 1; k <= 5; k++) vecs.push_back(mk(0, JUNK, 1, 0, 0, 1, 0));
    vecs.push_back(mk(0, JUNK, 1, 0, 1, 1, 0));
    vecs.push_back(mk(0, 24'h1, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, JUNK, 1, 24'h1, 0, 1, 0));
    vecs.push_back(mk(0, JUNK, 1, 24'h1, 1, 1, 0));
    for (int k = 10; k <= 12; k++) vecs.push_back(mk(0, 24'(k - 8), 1, 24'(k - 8), k < 12, 1, 0));
    vecs.push_back(mk(0, JUNK, 1, 24'h4, 1, 1, 0));
    vecs.push_back(mk(0, 24'h5, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, JUNK, 1, 24'h5, 0, 1, 0));
    vecs.push_back(mk(0, JUNK, 1, 24'h5, 1, 1, 0));
    for (int k = 17; k <= 19; k++) vecs.push_back(mk(0, 24'(k - 11), 1, 24'(k - 11), k < 19, 1, 0));
    vecs.push_back(mk(0, JUNK, 1, 24'h8, 0, 1, 0));
    for (int k = 21; k <= 31; k++) vecs.push_back(mk(0, JUNK, 1, 0, 0, 1, 0));
`else
    for (int k = 1; k <= 6; k++) vecs.push_back(mk(0, JUNK, 1, 0, 0, 1, 0));
    vecs.push_back(mk(0, JUNK, 1, 0, 1, 1, 0));
    for (int k = 8; k <= 11; k++) vecs.push_back(mk(0, 24'(k - 7), 1, 24'(k - 7), k < 11, 1, 0));
    vecs.push_back(mk(0, JUNK, 1, 0, 0, 1, 0));
    vecs.push_back(mk(0, JUNK, 1, 0, 1, 1, 0));
    for (int k = 14; k <= 17; k++) vecs.push_back(mk(0, 24'(k - 9), 1, 24'(k - 9), k < 17, 1, 0));
    for (int k = 18; k <= 29; k++) vecs.push_back(mk(0, JUNK, 1, 0, 0, 1, 0));
`endif
    vecs.push_back(mk(0, JUNK, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, JUNK, 0, 0, 0, 0, 0));

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    check("rst_oValid", 32'(sIf.oValid), 0);
    check("rst_oData",  32'(sIf.oData), 0);
    check("rst_iReady", 32'(sIf.iReady), 0);
    check("rst_oBusy",  32'(sIf.oBusy), 0);
    check("rst_oDone",  32'(sIf.oDone), 0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[k]) begin
      @(negedge clk);
      sIf.start  = vecs[k].start;
      sIf.iValid = vecs[k].iValid;
      sIf.iData  = pixel_t'(vecs[k].iData);
      @(posedge clk); #1;
      check($sformatf("v%0d_oValid", k), 32'(sIf.oValid), 32'(vecs[k].eValid));
      if (vecs[k].eValid)
        check($sformatf("v%0d_oData", k), 32'(sIf.oData), 32'(vecs[k].eData));
      check($sformatf("v%0d_iReady", k), 32'(sIf.iReady), 32'(vecs[k].eReady));
      check($sformatf("v%0d_oBusy", k), 32'(sIf.oBusy), 32'(vecs[k].eBusy));
      check($sformatf("v%0d_oDone", k), 32'(sIf.oDone), 32'(vecs[k].eDone));
    end

    // iValid toggling: bubbles only, same beat order and count.
    runFrame(1'b1, 1'b0, dn);
    compareBeats("toggle");
    check("toggle_dones", 32'(dn), 1);

    // Starts while busy and coincident with oDone are ignored.
    runFrame(1'b0, 1'b1, dn);
    compareBeats("pokeStart");
    check("pokeStart_dones", 32'(dn), 1);
    check("pokeStart_idleBusy", 32'(sIf.oBusy), 0);

    // A start in IDLE afterwards runs a full frame.
    runFrame(1'b0, 1'b0, dn);
    compareBeats("restart");
    check("restart_dones", 32'(dn), 1);

    // Reset during DATA of the second active row.
    begin : abortSeq
      int idx = 0;
      int n = 0;
      int dones = 0;
      bit acc;
      got.delete();
      while (got.size() < 15 && n < 100) begin
        @(negedge clk);
        sIf.start = (n == 0); sIf.iValid = 1'b1; sIf.iData = pixel_t'(24'(idx + 1));
        acc = sIf.iValid && sIf.iReady;
        @(posedge clk); #1;
        if (acc) idx++;
        if (sIf.oValid) got.push_back(sIf.oData);
        n++;
      end
      check("abort_reachedRow2", 32'(got.size()), 15);
      check("abort_inData", 32'(sIf.iReady), 1);
      @(negedge clk);
      reset = 1'b1; sIf.start = 1'b0;
      @(posedge clk); #1;
      check("abort_oValid", 32'(sIf.oValid), 0);
      check("abort_oBusy",  32'(sIf.oBusy), 0);
      check("abort_iReady", 32'(sIf.iReady), 0);
      check("abort_oDone",  32'(sIf.oDone), 0);
      @(negedge clk);
      reset = 1'b0;
      repeat (20) begin
        @(posedge clk); #1;
        if (sIf.oDone || sIf.oBusy) dones++;
      end
      check("abort_quiet", 32'(dones), 0);
    end
    runFrame(1'b0, 1'b0, dn);
    compareBeats("postAbort");
    check("postAbort_dones", 32'(dn), 1);

    // Default geometry: total non-bubble beats then one oDone.
    begin : fullSeq
      int beats = 0;
      int n = 0;
      int dones = 0;
      @(negedge clk);
      dIf.start = 1'b1; dIf.iValid = 1'b1; dIf.iData = pixel_t'(24'h123456);
      @(negedge clk);
      dIf.start = 1'b0;
      while (dones == 0 && n < 90000) begin
        @(posedge clk); #1;
        if (dIf.oValid) beats++;
        if (dIf.oDone) dones++;
        n++;
      end
      check("full_beats", 32'(beats), 32'd81190);
      check("full_done", 32'(dones), 1);
      @(posedge clk); #1;
      check("full_doneOneCycle", 32'(dIf.oDone), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
